analyzer_sequencer: RTL and testbench

Controller that runs a bank of go/done number-analyzer units (Fibonacci, even-number and similar FSMD checkers) against one operand, strictly one unit at a time. It accepts a number on a start pulse, drives each analyzer's go line in index order, captures its one-bit result, and releases it back to its initial state. It then reports the collected result vector with a single done pulse. It sits between the top-level operand source and the analyzer instances, so analyzers may share downstream resources without conflict.

---
 rtl/analyzer_sequencer_if.sv | 29 ++
 rtl/analyzer_sequencer.sv | 129 ++++++++++++
 tb/tb_analyzer_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/analyzer_sequencer_if.sv
// rtl/analyzer_sequencer_if.sv - operand/result and analyzer-bank signals of the sequencer
interface analyzer_sequencer_if #(
    parameter int N_AN  = 2,
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [WIDTH-1:0] number_i;
    logic             busy_o;
    logic             done_o;
    logic [N_AN-1:0]  results_o;
    logic [N_AN-1:0]  valid_o;
    logic [2:0]       state_o;
    logic [WIDTH-1:0] an_number_o;
    logic [N_AN-1:0]  an_go_o;
    logic [N_AN-1:0]  an_done_i;
    logic [N_AN-1:0]  an_result_i;

    // Sequencer side
    modport slave (
        input  start_i, number_i, an_done_i, an_result_i,
        output busy_o, done_o, results_o, valid_o, state_o, an_number_o, an_go_o
    );

    // Operand source / analyzer bank side
    modport master (
        output start_i, number_i, an_done_i, an_result_i,
        input  busy_o, done_o, results_o, valid_o, state_o, an_number_o, an_go_o
    );
endinterface

// File: rtl/analyzer_sequencer.sv
// rtl/analyzer_sequencer.sv - runs a bank of go/done analyzers one at a time against one operand
module analyzer_sequencer #(
    parameter int N_AN    = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    analyzer_sequencer_if.slave bus
);
    localparam int IDX_W = (N_AN > 1) ? $clog2(N_AN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [WIDTH-1:0] number_q,  number_d;
    logic [N_AN-1:0]  results_q, results_d;
    logic [N_AN-1:0]  valid_q,   valid_d;

    logic done_sel;
    logic result_sel;
    logic timer_last;
    logic idx_last;

    // Only the analyzer currently selected is observed; the others are ignored.
    assign done_sel   = bus.an_done_i[idx_q];
    assign result_sel = bus.an_result_i[idx_q];
    assign timer_last = (timer_q == TMR_W'(TIMEOUT - 1));
    assign idx_last   = (idx_q == IDX_W'(N_AN - 1));

    // Next-state and datapath decisions for the sequencing FSM
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        number_d  = number_q;
        results_d = results_q;
        valid_d   = valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    number_d  = bus.number_i;
                    results_d = '0;
                    valid_d   = '0;
                    idx_d     = '0;
                    timer_d   = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // A done seen on the final allowed cycle still counts as completion.
                if (done_sel) begin
                    results_d[idx_q] = result_sel;
                    valid_d[idx_q]   = 1'b1;
                    timer_d          = '0;
                    state_d          = S_RELEASE;
                end else if (timer_last) begin
                    results_d[idx_q] = 1'b0;
                    valid_d[idx_q]   = 1'b0;
                    timer_d          = '0;
                    state_d          = S_RELEASE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RELEASE: begin
                // Wait for the analyzer to fall back to its initial state, bounded
                // so a stuck done line cannot hang the whole bank.
                if (!done_sel || timer_last) begin
                    if (idx_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = '0;
                        state_d = S_RUN;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            number_q  <= '0;
            results_q <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            number_q  <= number_d;
            results_q <= results_d;
            valid_q   <= valid_d;
        end
    end

    // Go is decoded from registered state only, so it cannot glitch on analyzer inputs
    always_comb begin
        bus.an_go_o = '0;
        if (state_q == S_RUN) begin
            bus.an_go_o[idx_q] = 1'b1;
        end
    end

    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.state_o     = state_q;
    assign bus.results_o   = results_q;
    assign bus.valid_o     = valid_q;
    assign bus.an_number_o = number_q;
endmodule

// File: tb/tb_analyzer_sequencer.sv
// tb/tb_analyzer_sequencer.sv - self-checking bench for analyzer_sequencer with mock analyzers
module tb_analyzer_sequencer;
    localparam int N_AN    = 2;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 8;

    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 2;
    localparam int ST_REL  = 3;
    localparam int ST_DONE = 5;

    logic clk;
    logic rst;

    analyzer_sequencer_if #(.N_AN(N_AN), .WIDTH(WIDTH)) bus ();

    analyzer_sequencer #(.N_AN(N_AN), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Mock analyzer configuration: done in go cycle cfg_d (0 = never),
    // result cfg_r, done held cfg_h cycles after go falls.
    int              cfg_d [N_AN];
    int              cfg_h [N_AN];
    logic [N_AN-1:0] cfg_r;

    int              mk_cnt   [N_AN];
    int              mk_post  [N_AN];
    logic            mk_fired [N_AN];
    logic [N_AN-1:0] mk_done;
    logic [N_AN-1:0] mk_res;

    // Mock analyzer counters
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < N_AN; k++) begin
            if (rst) begin
                mk_cnt[k]   <= 0;
                mk_post[k]  <= 255;
                mk_fired[k] <= 1'b0;
            end else if (bus.an_go_o[k]) begin
                mk_cnt[k]   <= mk_cnt[k] + 1;
                mk_post[k]  <= 0;
                mk_fired[k] <= mk_done[k];
            end else begin
                mk_cnt[k]   <= 0;
                if (mk_post[k] < 255) mk_post[k] <= mk_post[k] + 1;
            end
        end
    end

    // Mock analyzer done/result outputs
    always_comb begin
        mk_done = '0;
        mk_res  = '0;
        for (int k = 0; k < N_AN; k++) begin
            if (bus.an_go_o[k]) mk_done[k] = (cfg_d[k] != 0) && (mk_cnt[k] >= cfg_d[k] - 1);
            else                mk_done[k] = mk_fired[k] && (mk_post[k] < cfg_h[k]);
            mk_res[k] = cfg_r[k];
        end
    end

    assign bus.an_done_i   = mk_done;
    assign bus.an_result_i = mk_res;

    // Model: a run is a schedule of (run length, release length) per analyzer
    int              m_cyc = 0;
    int              sd [N_AN];
    int              sr [N_AN];
    logic [N_AN-1:0] fin_res = '0, fin_val = '0;
    logic [N_AN-1:0] held_res = '0, held_val = '0;
    logic [WIDTH-1:0] m_num = '0;
    int              go_cnt [N_AN];
    int              done_cnt = 0;
    int              done_at  = 0;

    function automatic void model_at(input int m, output int st, output int gk);
        int t;
        st = ST_IDLE;
        gk = 0;
        if (m != 0) begin
            t = 1;
            st = -1;
            for (int k = 0; k < N_AN; k++) begin
                if (st < 0 && m < t + sd[k]) begin st = ST_RUN; gk = k; end
                t += sd[k];
                if (st < 0 && m < t + sr[k]) begin st = ST_REL; gk = k; end
                t += sr[k];
            end
            if (st < 0) st = (m == t) ? ST_DONE : ST_IDLE;
        end
    endfunction

    // Compare process: DUT outputs against the model on every cycle
    always @(negedge clk) begin
        int st, gk;
        logic [N_AN-1:0] exp_go;
        bit seen;
        if (rst) begin
            m_cyc    = 0;
            held_res = '0;
            held_val = '0;
            m_num    = '0;
            chk("rst_go", bus.an_go_o, 0);
            chk("rst_busy", bus.busy_o, 0);
            chk("rst_done", bus.done_o, 0);
            chk("rst_state", bus.state_o, 0);
            chk("rst_results", bus.results_o, 0);
            chk("rst_valid", bus.valid_o, 0);
            chk("rst_number", bus.an_number_o, 0);
        end else begin
            model_at(m_cyc, st, gk);
            exp_go = '0;
            if (st == ST_RUN) exp_go[gk] = 1'b1;
            chk("go", bus.an_go_o, exp_go);
            chk("busy", bus.busy_o, (st != ST_IDLE));
            chk("done", bus.done_o, (st == ST_DONE));
            chk("state", bus.state_o, st);
            chk("number", bus.an_number_o, m_num);
            if (st == ST_DONE) begin
                chk("results", bus.results_o, fin_res);
                chk("valid", bus.valid_o, fin_val);
            end else if (st == ST_IDLE) begin
                chk("results_hold", bus.results_o, held_res);
                chk("valid_hold", bus.valid_o, held_val);
            end
            for (int k = 0; k < N_AN; k++) if (bus.an_go_o[k]) go_cnt[k]++;
            if (bus.done_o) begin done_cnt++; done_at = m_cyc; end
            if (st == ST_DONE) begin
                held_res = fin_res;
                held_val = fin_val;
                m_cyc = 0;
            end else if (st == ST_IDLE) begin
                if (bus.start_i) begin
                    m_cyc = 1;
                    m_num = bus.number_i;
                    for (int k = 0; k < N_AN; k++) begin
                        seen = (cfg_d[k] != 0) && (cfg_d[k] <= TIMEOUT);
                        sd[k] = seen ? cfg_d[k] : TIMEOUT;
                        sr[k] = seen ? ((cfg_h[k] + 1 < TIMEOUT) ? cfg_h[k] + 1 : TIMEOUT) : 1;
                        fin_res[k] = seen & cfg_r[k];
                        fin_val[k] = seen;
                        go_cnt[k] = 0;
                    end
                end
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic set_cfg(input int d0, input bit r0, input int h0,
                           input int d1, input bit r1, input int h1);
        cfg_d[0] = d0; cfg_r[0] = r0; cfg_h[0] = h0;
        cfg_d[1] = d1; cfg_r[1] = r1; cfg_h[1] = h1;
    endtask

    // Pulse start for one cycle; returns #1 into the first RUN cycle
    task automatic start_pulse(input logic [WIDTH-1:0] n);
        bus.start_i  = 1'b1;
        bus.number_i = n;
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
    endtask

    // Wait for a done pulse (bounded), then confirm no further done appears
    task automatic wait_done(input string nm);
        int base;
        base = done_cnt;
        for (int i = 0; i < 300 && done_cnt == base; i++) @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_done_count"}, done_cnt - base, 1);
    endtask

    initial begin
        int base;
        bus.start_i  = 1'b0;
        bus.number_i = '0;
        set_cfg(1, 1'b0, 0, 1, 1'b0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset asserted for 3 cycles while idle
        rst = 1'b1;
        #1;
        chk("idle_rst_busy", bus.busy_o, 0);
        chk("idle_rst_state", bus.state_o, 0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("post_rst_state", bus.state_o, 0);

        // Normal run with a start pulse during RUN that must be ignored
        set_cfg(3, 1'b0, 0, 2, 1'b1, 0);
        start_pulse(88);
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.number_i = 13;
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
        wait_done("normal");
        chk("normal_results", bus.results_o, 2'b10);
        chk("normal_valid", bus.valid_o, 2'b11);
        chk("normal_number", bus.an_number_o, 88);
        chk("normal_go0_cycles", go_cnt[0], 3);
        chk("normal_go1_cycles", go_cnt[1], 2);
        chk("normal_done_cycle", done_at, 8);

        // Analyzer 0 never finishes
        set_cfg(0, 1'b1, 0, 2, 1'b1, 0);
        start_pulse(88);
        wait_done("timeout");
        chk("timeout_go0_cycles", go_cnt[0], 8);
        chk("timeout_valid", bus.valid_o, 2'b10);
        chk("timeout_results", bus.results_o, 2'b10);
        chk("timeout_done_cycle", done_at, 13);

        // Analyzer 1 keeps done high long after go falls
        set_cfg(1, 1'b1, 0, 3, 1'b1, 20);
        start_pulse(88);
        wait_done("sticky");
        chk("sticky_valid", bus.valid_o, 2'b11);
        chk("sticky_results", bus.results_o, 2'b11);
        chk("sticky_done_cycle", done_at, 14);

        // Start held through the DONE cycle: ignored there, accepted in IDLE
        set_cfg(3, 1'b0, 0, 2, 1'b1, 0);
        start_pulse(88);
        for (int i = 0; i < 300 && bus.state_o != 3'd5; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_done", bus.state_o, 5);
        bus.start_i  = 1'b1;
        bus.number_i = 13;
        @(posedge clk); #1;
        chk("done_start_ignored", bus.state_o, 0);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk("restart_number", bus.an_number_o, 13);
        chk("restart_go", bus.an_go_o, 2'b01);
        wait_done("restart");
        chk("restart_results", bus.results_o, 2'b10);

        // Reset in the middle of RUN
        set_cfg(5, 1'b1, 0, 2, 1'b1, 0);
        start_pulse(88);
        chk("pre_rst_go", bus.an_go_o, 2'b01);
        base = done_cnt;
        rst = 1'b1;
        #1;
        chk("midrun_rst_go", bus.an_go_o, 0);
        chk("midrun_rst_busy", bus.busy_o, 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("midrun_no_done", done_cnt - base, 0);
        start_pulse(7);
        chk("after_rst_go", bus.an_go_o, 2'b01);
        wait_done("after_rst");
        chk("after_rst_results", bus.results_o, 2'b11);
        chk("after_rst_valid", bus.valid_o, 2'b11);
        chk("after_rst_go0_cycles", go_cnt[0], 5);
        chk("after_rst_number", bus.an_number_o, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
